// File: rtl/aes_inv_cipher_ctrl.sv
// Iterative AES inverse-cipher controller: one decryption round per clock,
// round keys fetched by index from an async-read key store.
module aes_inv_cipher_ctrl #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy,
    output logic [3:0]   round
);

    localparam logic [3:0] NR4 = 4'(NR);

    // Entry b sits at bit offset (255-b)*8, i.e. row 0 of the table is leftmost.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_e;

    state_e       fsm_q, fsm_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] blk_q, blk_d;
    logic [127:0] out_q, out_d;

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int unsigned i = 0; i < 16; i++)
            r[127 - 8*i -: 8] = inv_sbox(s[127 - 8*i -: 8]);
        return r;
    endfunction

    // Byte (row r, column c) lives at index 4*c + r; row r rotates right by r.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int unsigned c = 0; c < 4; c++)
            for (int unsigned w = 0; w < 4; w++)
                r[127 - 8*(4*c + w) -: 8] = s[127 - 8*(4*((c + 4 - w) % 4) + w) -: 8];
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] a2, a4, a8;
        a2 = xtime(a);
        a4 = xtime(a2);
        a8 = xtime(a4);
        return (k[3] ? a8 : 8'h00) ^ (k[2] ? a4 : 8'h00) ^
               (k[1] ? a2 : 8'h00) ^ (k[0] ? a  : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9),
                gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd),
                gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb),
                gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he)};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int unsigned c = 0; c < 4; c++)
            r[127 - 32*c -: 32] = inv_mix_column(s[127 - 32*c -: 32]);
        return r;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q   <= IDLE;
            round_q <= NR4;
            blk_q   <= '0;
            out_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            round_q <= round_d;
            blk_q   <= blk_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        round_d = round_q;
        blk_d   = blk_q;
        out_d   = out_q;
        rk_idx  = NR4;
        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    blk_d   = in_data ^ rk_data;
                    round_d = NR4 - 4'd1;
                    fsm_d   = ROUND;
                end
            end
            ROUND: begin
                rk_idx  = round_q;
                blk_d   = inv_mix_columns(inv_sub_bytes(inv_shift_rows(blk_q)) ^ rk_data);
                // Leaving round 1 lands the counter on 0, which FINAL reports.
                round_d = round_q - 4'd1;
                if (round_q == 4'd1)
                    fsm_d = FINAL;
            end
            FINAL: begin
                rk_idx = 4'd0;
                out_d  = inv_sub_bytes(inv_shift_rows(blk_q)) ^ rk_data;
                fsm_d  = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    round_d = NR4;
                    fsm_d   = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    assign in_ready  = (fsm_q == IDLE);
    assign out_valid = (fsm_q == DONE);
    assign busy      = (fsm_q == ROUND) || (fsm_q == FINAL);
    assign round     = round_q;
    assign out_data  = out_q;

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// Bench for aes_inv_cipher_ctrl: FIPS-197 vectors on NR=10 and NR=14 instances,
// key store filled by a behavioural key expansion.
module tb_aes_inv_cipher_ctrl;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] in_data, rk_data, out_data;
    logic [3:0]   rk_idx, round;
    logic         in_valid14, in_ready14, out_valid14, out_ready14, busy14;
    logic [127:0] in_data14, rk_data14, out_data14;
    logic [3:0]   rk_idx14, round14;

    logic [127:0] rk10 [0:15];
    logic [127:0] rk14 [0:15];
    logic [127:0] rk_tmp [0:15];
    logic [127:0] exp_q [$];
    logic [3:0]   rk_log [$];

    typedef struct {
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;
    vec_t tbl [3];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int edges, busy_cnt, n;
    int acc_cyc [3];

    assign rk_data   = rk10[rk_idx];
    assign rk_data14 = rk14[rk_idx14];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_inv_cipher_ctrl #(.NR(10)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .rk_idx(rk_idx), .rk_data(rk_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy), .round(round)
    );

    aes_inv_cipher_ctrl #(.NR(14)) dut14 (
        .clk(clk), .reset(reset), .in_valid(in_valid14), .in_ready(in_ready14),
        .in_data(in_data14), .rk_idx(rk_idx14), .rk_data(rk_data14), .out_valid(out_valid14),
        .out_ready(out_ready14), .out_data(out_data14), .busy(busy14), .round(round14)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xt(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // Forward S-box from its definition: multiplicative inverse then affine map.
    function automatic logic [7:0] fsbox(input logic [7:0] x);
        logic [7:0] v;
        v = 8'h00;
        if (x != 8'h00) begin
            v = 8'h01;
            for (int i = 0; i < 254; i++) v = gmul(v, x);
        end
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {fsbox(w[31:24]), fsbox(w[23:16]), fsbox(w[15:8]), fsbox(w[7:0])};
    endfunction

    task automatic expand_key(input logic [255:0] key, input int nr);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rcon;
        int nk;
        nk = nr - 6;
        rcon = 8'h01;
        for (int i = 0; i < 60; i++) w[i] = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h000000};
                rcon = xt(rcon);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++)
            rk_tmp[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
    endtask

    task automatic load10(input logic [127:0] key);
        expand_key({key, 128'h0}, 10);
        for (int r = 0; r < 16; r++) rk10[r] = rk_tmp[r];
    endtask

    task automatic load14(input logic [255:0] key);
        expand_key(key, 14);
        for (int r = 0; r < 16; r++) rk14[r] = rk_tmp[r];
    endtask

    // Waits until every queued plaintext has left, then steps off the handshake edge.
    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 40) begin
            @(posedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            timeout(name);
            exp_q.delete();
        end
        #1;
    endtask

    // Scoreboard: compare each plaintext handed over against the oldest expectation.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                timeout("sb_unexpected_output");
            end else begin
                chk("sb_out_data", out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid = 0; in_data = '0; out_ready = 0;
        in_valid14 = 0; in_data14 = '0; out_ready14 = 0;
        for (int r = 0; r < 16; r++) begin rk10[r] = '0; rk14[r] = '0; end
        #1 reset = 1;
        #2;
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_out_data", out_data, '0);
        chk("rst_round", 128'(round), 128'(10));
        chk("rst_rk_idx", 128'(rk_idx), 128'(10));
        chk("rst_round14", 128'(round14), 128'(14));
        @(posedge clk);
        @(posedge clk); #3 reset = 0;

        // C.1 decrypt with per-cycle key-index log
        load10(C1_KEY);
        @(posedge clk); #1 in_valid = 1; in_data = C1_CT; exp_q.push_back(C1_PT);
        @(negedge clk);
        chk("t1_accept_rk_idx", 128'(rk_idx), 128'(10));
        chk("t1_accept_ready", 128'(in_ready), 128'(1));
        @(posedge clk); #1 in_valid = 0;
        edges = 1; busy_cnt = 0; rk_log.delete();
        @(negedge clk);
        while (!out_valid && edges < 40) begin
            rk_log.push_back(rk_idx);
            busy_cnt += int'(busy);
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        if (!out_valid) timeout("t1_out_valid");
        // acceptance edge counted as the first of the 11
        chk("t1_latency", 128'(edges), 128'(11));
        chk("t1_out_data", out_data, C1_PT);
        chk("t2_rk_log_len", 128'(rk_log.size()), 128'(10));
        for (int k = 0; k < rk_log.size() && k < 10; k++)
            chk($sformatf("t2_rk_seq_%0d", k), 128'(rk_log[k]), 128'(9 - k));
        chk("t2_busy_cycles", 128'(busy_cnt), 128'(10));
        chk("t2_done_rk_idx", 128'(rk_idx), 128'(10));
        chk("t2_done_busy", 128'(busy), 128'(0));

        // Backpressure: five stalled DONE cycles with a second block waiting
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_valid", 128'(out_valid), 128'(1));
            chk("t3_hold_data", out_data, C1_PT);
            chk("t3_hold_in_ready", 128'(in_ready), 128'(0));
            chk("t3_hold_busy", 128'(busy), 128'(0));
            @(posedge clk); #1;
            if (i == 0) begin in_valid = 1; in_data = C1_CT; exp_q.push_back(C1_PT); end
            if (i == 4) out_ready = 1;
            @(negedge clk);
        end
        chk("t3_valid_at_handshake", 128'(out_valid), 128'(1));
        chk("t3_in_ready_at_handshake", 128'(in_ready), 128'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk("t3_in_ready_after", 128'(in_ready), 128'(1));
        chk("t3_out_valid_after", 128'(out_valid), 128'(0));
        chk("t3_out_data_kept", out_data, C1_PT);
        @(posedge clk); #1 in_valid = 0;
        @(negedge clk);
        chk("t3_second_accepted", 128'(busy), 128'(1));
        wait_drain("t3_drain");

        // Back-to-back table vectors with a key reload between blocks
        tbl[0] = '{key: 128'h0, ct: Z_CT, pt: 128'h0};
        tbl[1] = '{key: B_KEY, ct: B_CT, pt: B_PT};
        tbl[2] = '{key: C1_KEY, ct: C1_CT, pt: C1_PT};
        for (int i = 0; i < 3; i++) begin
            load10(tbl[i].key);
            in_valid = 1; in_data = tbl[i].ct; exp_q.push_back(tbl[i].pt);
            @(negedge clk);
            chk($sformatf("t4_ready_%0d", i), 128'(in_ready), 128'(1));
            @(posedge clk); #1;
            acc_cyc[i] = cyc;
            in_valid = 0;
            n = 0;
            @(negedge clk);
            while (!out_valid && n < 40) begin
                @(negedge clk);
                n++;
            end
            if (!out_valid) timeout($sformatf("t4_out_valid_%0d", i));
            @(posedge clk); #1;
        end
        chk("t4_spacing_1", 128'(acc_cyc[1] - acc_cyc[0]), 128'(12));
        chk("t4_spacing_2", 128'(acc_cyc[2] - acc_cyc[1]), 128'(12));
        chk("t4_queue_empty", 128'(exp_q.size()), 128'(0));

        // Asynchronous reset in the 4th ROUND cycle
        load10(C1_KEY);
        in_valid = 1; in_data = C1_CT; exp_q.push_back(C1_PT);
        @(posedge clk); #1 in_valid = 0;
        repeat (3) @(posedge clk);
        #2;
        chk("t5_busy_before", 128'(busy), 128'(1));
        chk("t5_round_before", 128'(round), 128'(6));
        reset = 1;
        #1;
        chk("t5_out_valid", 128'(out_valid), 128'(0));
        chk("t5_out_data", out_data, '0);
        chk("t5_busy", 128'(busy), 128'(0));
        chk("t5_in_ready", 128'(in_ready), 128'(1));
        chk("t5_round", 128'(round), 128'(10));
        exp_q.delete();
        @(posedge clk); #3 reset = 0;
        @(posedge clk); #1 in_valid = 1; in_data = C1_CT; exp_q.push_back(C1_PT);
        @(posedge clk); #1 in_valid = 0;
        wait_drain("t5_drain");

        // AES-256 instance
        load14(C3_KEY);
        @(posedge clk); #1 in_valid14 = 1; in_data14 = C3_CT;
        @(negedge clk);
        chk("t6_accept_rk_idx", 128'(rk_idx14), 128'(14));
        @(posedge clk); #1 in_valid14 = 0;
        edges = 1;
        @(negedge clk);
        while (!out_valid14 && edges < 60) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        if (!out_valid14) timeout("t6_out_valid");
        chk("t6_latency", 128'(edges), 128'(15));
        chk("t6_out_data", out_data14, C1_PT);
        chk("t6_busy_done", 128'(busy14), 128'(0));
        @(posedge clk); #1 out_ready14 = 1;
        @(posedge clk); #1 out_ready14 = 0;
        @(negedge clk);
        chk("t6_in_ready_after", 128'(in_ready14), 128'(1));
        chk("t6_out_valid_after", 128'(out_valid14), 128'(0));
        chk("t6_round_after", 128'(round14), 128'(14));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
